// File: rtl/button_debounce.sv
// Multi-channel pushbutton conditioner: two-flop synchronizer, per-channel
// stability counter, debounced level plus one-cycle press/release strobes.

module button_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1330000,
  parameter int CNT_WIDTH       = 21,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clock,
  input  logic resetn,
  input  logic pin,
  output logic state,
  output logic pressed,
  output logic released
);
  localparam logic                 INACTIVE = 1'(ACTIVE_LOW != 0);
  localparam logic [CNT_WIDTH-1:0] LAST     = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1, sync2;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 act;

  assign act = sync2 ^ INACTIVE;

  // Sync flops reset to the idle pin level so reset release never looks like a press.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1    <= INACTIVE;
      sync2    <= INACTIVE;
      cnt      <= '0;
      state    <= 1'b0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      sync1    <= pin;
      sync2    <= sync1;
      pressed  <= 1'b0;
      released <= 1'b0;
      if (act == state) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        state    <= act;
        cnt      <= '0;
        pressed  <= act;
        released <= ~act;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end
endmodule

module button_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1330000,
  parameter int CNT_WIDTH       = 21,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] buttons_pin,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released
);
  button_debounce_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_lane [WIDTH-1:0] (
    .clock   (clock),
    .resetn  (resetn),
    .pin     (buttons_pin),
    .state   (state),
    .pressed (pressed),
    .released(released)
  );
endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed plan plus random pin activity, checked
// against a sliding-window model on two instances (DEBOUNCE_CYCLES 4 and 1).

module tb_button_debounce;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] pins = 4'hF;
  logic [3:0] st4, pr4, rl4, st1, pr1, rl1;

  button_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .ACTIVE_LOW(1)) dut4 (
    .clock(clock), .resetn(resetn), .buttons_pin(pins),
    .state(st4), .pressed(pr4), .released(rl4));

  button_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(1), .ACTIVE_LOW(1)) dut1 (
    .clock(clock), .resetn(resetn), .buttons_pin(pins),
    .state(st1), .pressed(pr1), .released(rl1));

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: a change is accepted when the last D normalized samples, all taken
  // after the previous change (or reset), disagree with the current level.
  logic [3:0] pin_hist[$];
  logic [3:0] act_hist[$];
  logic [3:0] m_state [2];
  logic [3:0] m_pr    [2];
  logic [3:0] m_rl    [2];
  int         age     [2][4];
  int         dcyc    [2] = '{4, 1};

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pin_hist.delete();
    pin_hist.push_front(4'hF);
    pin_hist.push_front(4'hF);
    act_hist.delete();
    for (int m = 0; m < 2; m++) begin
      m_state[m] = '0; m_pr[m] = '0; m_rl[m] = '0;
      for (int c = 0; c < 4; c++) age[m][c] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] act;
    logic       ok;
    pin_hist.push_front(pins);
    act = ~pin_hist[2];           // pin seen two edges ago, pressed = 1
    while (pin_hist.size() > 3) void'(pin_hist.pop_back());
    act_hist.push_front(act);
    while (act_hist.size() > 4) void'(act_hist.pop_back());
    for (int m = 0; m < 2; m++) begin
      m_pr[m] = '0; m_rl[m] = '0;
      for (int c = 0; c < 4; c++) begin
        age[m][c]++;
        if (age[m][c] >= dcyc[m]) begin
          ok = 1'b1;
          for (int j = 0; j < dcyc[m]; j++)
            if (act_hist[j][c] == m_state[m][c]) ok = 1'b0;
          if (ok) begin
            m_state[m][c] = ~m_state[m][c];
            if (m_state[m][c]) m_pr[m][c] = 1'b1;
            else               m_rl[m][c] = 1'b1;
            age[m][c] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("state4", st4, m_state[0]);
    chk("pressed4", pr4, m_pr[0]);
    chk("released4", rl4, m_rl[0]);
    chk("state1", st1, m_state[1]);
    chk("pressed1", pr1, m_pr[1]);
    chk("released1", rl1, m_rl[1]);
    chk("excl4", pr4 & rl4, 4'h0);
    chk("excl1", pr1 & rl1, 4'h0);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, cnt_p, cnt_r;

    // Reset with all pins released
    model_reset();
    #12;
    chk("rst_state4", st4, 4'h0);
    chk("rst_strobe4", pr4 | rl4, 4'h0);
    chk("rst_state1", st1, 4'h0);
    @(negedge clock);
    resetn = 1'b1;
    cnt_p = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      cnt_p += (st4 != 0 || pr4 != 0 || rl4 != 0) ? 1 : 0;
    end
    chk_int("idle_after_reset", cnt_p, 0);

    // Clean press and release on channel 0
    pins[0] = 1'b0;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step();
      if (pr4[0]) n = i;
    end
    chk_int("press_latency", n, 6);
    chk("press_state", st4, 4'b0001);
    step();
    chk("press_width", pr4, 4'h0);
    idle(3);
    pins[0] = 1'b1;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step();
      if (rl4[0]) n = i;
    end
    chk_int("release_latency", n, 6);
    chk("release_state", st4, 4'h0);
    idle(5);

    // Bounce on channel 1: only the final stable run qualifies
    cnt_p = 0;
    foreach (dcyc[k]) ;
    begin
      logic [8:0] pat;
      pat = 9'b000010010;         // applied LSB-first: 0,1,0,0,1,0,0,0,0
      for (int i = 0; i < 9; i++) begin
        pins[1] = pat[i];
        step();
        cnt_p += pr4[1];
      end
    end
    for (int i = 0; i < 10; i++) begin
      step();
      cnt_p += pr4[1];
    end
    chk_int("bounce_presses", cnt_p, 1);
    chk("bounce_state", st4, 4'b0010);
    pins[1] = 1'b1;
    idle(10);

    // Three-cycle glitch on channel 3 must be rejected by the D=4 instance
    cnt_p = 0;
    pins[3] = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); cnt_p += pr4[3] + rl4[3]; end
    pins[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); cnt_p += pr4[3] + rl4[3]; end
    chk_int("glitch_strobes", cnt_p, 0);
    chk("glitch_state", st4, 4'h0);

    // Channels 0 and 3 pressed on the same edge
    pins = 4'b0110;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step();
      if (pr4 != 0) n = i;
    end
    chk_int("simul_latency", n, 6);
    chk("simul_pressed", pr4, 4'b1001);
    chk("simul_state", st4, 4'b1001);
    pins = 4'hF;
    idle(10);

    // Reset while channel 2 is held
    pins = 4'b1011;
    idle(10);
    chk("held_state", st4, 4'b0100);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("reset_held_state4", st4, 4'h0);
    chk("reset_held_rel4", rl4, 4'h0);
    chk("reset_held_state1", st1, 4'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
    n = 0;
    cnt_r = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step();
      cnt_r += rl4[2];
      if (pr4[2]) n = i;
    end
    chk_int("requalify_latency", n, 6);
    chk_int("no_release_on_reset", cnt_r, 0);
    pins = 4'hF;
    idle(10);

    // Fast path: one-cycle pulse on channel 0 through the D=1 instance
    pins[0] = 1'b0;
    n = 0; cnt_p = 0; cnt_r = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      pins[0] = 1'b1;
      if (pr1[0] && n == 0) n = i;
      cnt_p += pr1[0];
      cnt_r += rl1[0];
    end
    chk_int("fast_latency", n, 3);
    chk_int("fast_presses", cnt_p, 1);
    chk_int("fast_releases", cnt_r, 1);

    // Random pin activity, model checked every edge
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(5) == 0) pins[c] = ~pins[c];
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/button_debounce.md
# button_debounce

Multi-channel pushbutton input conditioner: the input-side counterpart to the LED output path. It synchronizes raw, bouncing button pins into the `clock` domain, filters them with per-channel stability counters, and presents clean level outputs plus single-cycle press/release strobes. It sits between the board button pins and application logic, in the same `clock`/`resetn` domain produced by `resetn_gen` from the on-chip oscillator.

## Interface
- `WIDTH`, default 8: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 1330000: consecutive stable cycles required to accept a change. This is 10 ms at 133 MHz. Legal range is 1 to 2^CNT_WIDTH-1.
- `CNT_WIDTH`, default 21: width of each per-channel stability counter.
- `ACTIVE_LOW`, default 1: 1 means a pin at 0 is "pressed"; 0 means a pin at 1 is "pressed".

Ports:
- `clock`  in  1: single system clock; all logic on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `buttons_pin`  in  WIDTH: raw asynchronous button pins.
- `state`  out  WIDTH: debounced level per channel; 1 = pressed.
- `pressed`  out  WIDTH: one-cycle strobe on an accepted 0→1 of `state`.
- `released`  out  WIDTH: one-cycle strobe on an accepted 1→0 of `state`.

## Operation
- **Synchronizer:** per channel, two flops `sync1` → `sync2`, both clocked by `clock` and both reset by `resetn`.
  - Reset value is the inactive pin level: 1 if `ACTIVE_LOW`, else 0. Release of reset therefore never produces a spurious press.
- **Normalized input:** `act = sync2 ^ ACTIVE_LOW`, so 1 = pressed.
- **Per-channel stability counter `cnt`** (CNT_WIDTH bits). Every edge, each channel does exactly one of the following:
  - `act == state`: `cnt` ← 0 and no strobe.
  - `act != state` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` ← `cnt`+1.
  - `act != state` and `cnt == DEBOUNCE_CYCLES-1`: `state` ← `act`, `cnt` ← 0, and the matching strobe (`pressed` or `released`) is driven to 1 for this one cycle.
- **Bounce rejection:** any single cycle with `act == state` restarts the count from 0. There is no partial credit.
- **Strobes:**
  - `pressed` and `released` are registered and asserted in the same cycle that `state` takes its new value.
  - They are deasserted on the following edge.
  - A channel never asserts `pressed` and `released` together.
- **Channel independence:** channels are fully independent. Any combination of channels may strobe in the same cycle.
- **Counter range:** `cnt` never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- **DEBOUNCE_CYCLES = 1:** a change is accepted on the first cycle `act` differs from `state`.
- **Reset values** (asynchronous, on `resetn` low): `state` = 0, `pressed` = 0, `released` = 0, all `cnt` = 0, sync flops at the inactive level.
- **Reset mid-operation:**
  - Asserting reset while a button is held clears `state` immediately with no `released` strobe.
  - After reset release, a still-held button re-qualifies and produces `pressed` after the full latency.

## Timing
- Let pin level L be stable and captured by `sync1` at edge k. Then:
  - `sync2` = L after edge k+1.
  - Counting cycles are edges k+2 … k+1+DEBOUNCE_CYCLES.
  - `state` and the strobe update after edge k+1+DEBOUNCE_CYCLES.
- Minimum latency from first capture edge to `state` change: DEBOUNCE_CYCLES+1 edges after capture, i.e. visible DEBOUNCE_CYCLES+2 cycles from pin change.
- Strobe width: exactly 1 cycle.
- Minimum spacing between two strobes on one channel: DEBOUNCE_CYCLES cycles.
- Outputs are registered with no combinational path from `buttons_pin`.

## Test plan
Benches use `WIDTH`=4, `DEBOUNCE_CYCLES`=4, `ACTIVE_LOW`=1.
- **Reset with all pins 1:** hold `resetn` low, then release it with all pins at 1 → `state`=0000 and no strobes for 20 cycles.
- **Clean press:** drive pin0 to 0 and hold it → `pressed[0]`=1 for exactly one cycle, together with `state[0]`=1, 6 cycles after the pin change. Then release pin0 → `released[0]` pulses after the same latency and `state[0]` returns to 0.
- **Bounce:**
  - pin1 toggles 0,1,0,0,1,0,0,0,0,… → `state[1]` changes only after 4 consecutive `act`=1 counting cycles, and only one `pressed[1]` pulse occurs.
  - A glitch of 3 cycles at 0 → no change and no strobe.
- **Simultaneous channels:** pins 0 and 3 fall on the same edge → `pressed`=1001 in a single cycle, and `state`=1001.
- **Reset while held:** hold pin2 low until `state[2]`=1, then pulse `resetn` low → `state`=0 immediately and no `released[2]`. After release, with pin2 still low → `pressed[2]` after 6 cycles.
- **Fast path with `DEBOUNCE_CYCLES`=1:** a single-cycle pin pulse of 0 → `state` follows it with 3 cycles latency, with one `pressed` and one `released` strobe.
